// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial frame feeder: clears a downstream checker, shifts L bits
// MSB-first into it, then samples the checker's result.
`timescale 1ns/1ps
module serial_frame_feeder #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    output logic             in_ready,
    output logic             clr_n,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             res_in,
    output logic             res_out,
    output logic             res_valid
);
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, SAMPLE} state_t;

    localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);
    localparam logic [LW-1:0] ONE     = LW'(1);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    cnt_q;
    logic             clr_q;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (l > LEN_MAX) ? LEN_MAX : l;
    endfunction

    function automatic logic pick(input logic [WIDTH-1:0] d, input logic [LW-1:0] i);
        logic [WIDTH-1:0] s;
        s = d >> i;
        return s[0];
    endfunction

    // Gated with resetn so the checker sees a clear for the whole reset interval.
    assign clr_n = resetn & clr_q;

    // Payload word is only consumed while the frame runs, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid)
            data_q <= in_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            clr_q     <= 1'b1;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            res_out   <= 1'b0;
            res_valid <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= CLEAR;
                        len_q    <= clamp_len(in_len);
                        in_ready <= 1'b0;
                        clr_q    <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_q <= 1'b1;
                    if (len_q != '0) begin
                        // cnt_q holds the bit index currently on ser_bit.
                        state     <= SHIFT;
                        cnt_q     <= len_q - ONE;
                        ser_bit   <= pick(data_q, len_q - ONE);
                        ser_valid <= 1'b1;
                        ser_last  <= (len_q == ONE);
                    end else begin
                        state <= SAMPLE;
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        state     <= SAMPLE;
                        ser_bit   <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q - ONE;
                        ser_bit  <= pick(data_q, cnt_q - ONE);
                        ser_last <= (cnt_q == ONE);
                    end
                end
                SAMPLE: begin
                    res_out   <= res_in;
                    res_valid <= 1'b1;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    clr_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_feeder.sv
// Bench for serial_frame_feeder: frame-timeline model plus a mod-5 serial checker
// feeding res_in, with directed literal cases and randomized traffic.
`timescale 1ns/1ps
module tb_serial_frame_feeder;
    localparam int WIDTH = 8;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [LW-1:0]    in_len;
    logic             in_ready, clr_n, ser_bit, ser_valid, ser_last;
    logic             res_in, res_out, res_valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    serial_frame_feeder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_len(in_len), .in_ready(in_ready), .clr_n(clr_n), .ser_bit(ser_bit),
        .ser_valid(ser_valid), .ser_last(ser_last), .res_in(res_in),
        .res_out(res_out), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    // Downstream checker: remainder mod 5 of the MSB-first bit stream.
    logic [2:0] rem;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        rem <= 3'd0;
        else if (!clr_n)    rem <= 3'd0;
        else if (ser_valid) rem <= 3'((int'(rem) * 2 + int'(ser_bit)) % 5);
    end
    assign res_in = (rem == 3'd0);

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_e = rising edges since the transfer edge of the current frame.
    bit   m_act = 0;
    int   m_e   = 0;
    int   m_len = 0;
    logic [WIDTH-1:0] m_data = '0;
    bit   m_res = 0;
    bit   m_rdy;

    initial forever begin
        @(posedge clk);
        if (!resetn) begin
            m_act = 0; m_e = 0; m_res = 0;
        end else begin
            m_rdy = !m_act || (m_e >= m_len + 2);
            if (m_act && m_e < 100) begin
                m_e++;
                if (m_e == m_len + 2)
                    m_res = ((int'(m_data) % (1 << m_len)) % 5) == 0;
            end
            if (in_valid && m_rdy) begin
                m_act  = 1;
                m_e    = 0;
                m_data = in_data;
                m_len  = (int'(in_len) > WIDTH) ? WIDTH : int'(in_len);
            end
        end
    end

    logic e_rdy, e_clr, e_sv, e_sb, e_sl, e_rv, e_ro;
    initial forever begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            if (!resetn) begin
                e_rdy = 1; e_clr = 0; e_sv = 0; e_sb = 0; e_sl = 0; e_rv = 0; e_ro = 0;
            end else begin
                e_rdy = !m_act || (m_e >= m_len + 2);
                e_clr = !(m_act && m_e == 0);
                e_sv  = m_act && m_e >= 1 && m_e <= m_len;
                e_sb  = e_sv && (((m_data >> (m_len - m_e)) & 8'd1) != 8'd0);
                e_sl  = e_sv && (m_e == m_len);
                e_rv  = m_act && (m_e == m_len + 2);
                e_ro  = m_res;
            end
            check("in_ready", in_ready, e_rdy);
            check("clr_n", clr_n, e_clr);
            check("ser_valid", ser_valid, e_sv);
            check("ser_bit", ser_bit, e_sb);
            check("ser_last", ser_last, e_sl);
            check("res_valid", res_valid, e_rv);
            check("res_out", res_out, e_ro);
        end
    end

    // Sends one word and pins the serial bits, result and result latency.
    task automatic run_case(input string name, input logic [7:0] d, input logic [3:0] l,
                            input logic [15:0] eb, input int enb, input logic er, input int erv);
        logic [15:0] bits;
        int nb, rv, g;
        logic res;
        bits = '0; nb = 0; rv = -1; g = 0; res = 1'b0;
        while (!in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        in_valid = 1'b1; in_data = d; in_len = l;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (ser_valid) begin
                bits = {bits[14:0], ser_bit};
                nb++;
            end
            if (res_valid) begin
                res = res_out;
                rv = c;
                break;
            end
            @(negedge clk);
        end
        checki({name, " nbits"}, nb, enb);
        checki({name, " bits"}, int'(bits), int'(eb));
        check({name, " res_out"}, res, er);
        checki({name, " res_latency"}, rv, erv);
    endtask

    int cnt;
    initial begin
        resetn = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0;
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1'b1);
        check("rst clr_n", clr_n, 1'b0);
        check("rst ser_valid", ser_valid, 1'b0);
        check("rst res_valid", res_valid, 1'b0);
        check("rst res_out", res_out, 1'b0);
        resetn = 1'b1;
        chk_en = 1;

        run_case("w05", 8'h05, 4'd3, 16'b101, 3, 1'b1, 5);
        run_case("w06", 8'h06, 4'd3, 16'b110, 3, 1'b0, 5);
        run_case("w0A", 8'h0A, 4'd4, 16'b1010, 4, 1'b1, 6);
        run_case("len0", 8'hFF, 4'd0, 16'b0, 0, 1'b1, 2);
        run_case("len9", 8'hA6, 4'd9, 16'h00A6, 8, 1'b0, 10);

        // in_valid held high: one frame every L+3 cycles.
        in_valid = 1'b1; in_data = 8'h05; in_len = 4'd3; cnt = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        in_valid = 1'b0;
        checki("b2b frames", cnt, 3);

        // Reset during the second SHIFT cycle.
        in_valid = 1'b1; in_data = 8'h05; in_len = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("abort ser_valid", ser_valid, 1'b0);
        check("abort ser_bit", ser_bit, 1'b0);
        check("abort ser_last", ser_last, 1'b0);
        check("abort clr_n", clr_n, 1'b0);
        check("abort res_valid", res_valid, 1'b0);
        check("abort res_out", res_out, 1'b0);
        check("abort in_ready", in_ready, 1'b1);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        checki("abort no res_valid", cnt, 0);
        resetn = 1'b1;
        run_case("after_abort", 8'h05, 4'd3, 16'b101, 3, 1'b1, 5);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            resetn   = ($urandom_range(0, 149) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 8'($urandom);
            in_len   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 8));
        end
        @(negedge clk);
        resetn = 1'b1; in_valid = 1'b0;
        repeat (15) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
